// File: rtl/mips_multicycle_core_if.sv
// rtl/mips_multicycle_core_if.sv - instruction and data memory req/ready bundle
interface mips_multicycle_core_if #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 10,
    parameter int DADDR_W = 10
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [15:0]        imem_data;
    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ready;
    logic [DATA_W-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle 16-bit-encoding MIPS core with req/ready memories
module mips_multicycle_core #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 10,
    parameter int DADDR_W  = 10,
    parameter int RESET_PC = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    mips_multicycle_core_if.master mem,
    output logic [DATA_W-1:0]      alu_out,
    output logic [15:0]            ir,
    output logic                   halted
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state, state_next;
    logic [PC_W-1:0]    pc;
    logic [15:0]        ir_q;
    logic [DATA_W-1:0]  a_q, b_q, alu_q, mdr_q;
    logic [DATA_W-1:0]  rf [0:3];

    logic [3:0]         op;
    logic [1:0]         rs, rt, rd, wb_dest;
    logic signed [7:0]  imm8;
    logic [DATA_W-1:0]  imm, src2, diff, alu_res;
    logic [PC_W-1:0]    pc_off;
    logic               is_rtype, is_mem, zero;

    assign op       = ir_q[15:12];
    assign rs       = ir_q[11:10];
    assign rt       = ir_q[9:8];
    assign rd       = ir_q[7:6];
    assign imm8     = ir_q[7:0];
    assign imm      = DATA_W'(imm8);
    assign pc_off   = PC_W'(imm8);
    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                      (op == OP_OR)  || (op == OP_SLT);
    assign is_mem   = (op == OP_LW) || (op == OP_SW);
    assign wb_dest  = is_rtype ? rd : rt;

    always_comb begin
        src2 = (op == OP_ADDI || is_mem) ? imm : b_q;
        diff = a_q - b_q;
        case (op)
            OP_SUB, OP_BEQ: alu_res = diff;
            OP_AND:         alu_res = a_q & b_q;
            OP_OR:          alu_res = a_q | b_q;
            OP_SLT:         alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default:        alu_res = a_q + src2;
        endcase
    end

    assign zero = (diff == '0);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem.imem_ready) state_next = S_DECODE;
            S_DECODE: state_next = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_rtype || op == OP_ADDI) state_next = S_WB;
                else if (is_mem)               state_next = S_MEM;
                else                           state_next = S_FETCH;
            end
            S_MEM:    if (mem.dmem_ready) state_next = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Requests are gated by reset_n so an in-flight handshake is dropped in the reset cycle itself.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        halted       = 1'b0;
        if (reset_n) begin
            case (state)
                S_FETCH: mem.imem_req = 1'b1;
                S_MEM: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (op == OP_SW);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem.imem_addr  = pc;
    assign mem.dmem_addr  = alu_q[DADDR_W-1:0];
    assign mem.dmem_wdata = b_q;
    assign alu_out        = alu_q;
    assign ir             = ir_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc    <= PC_W'(RESET_PC);
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem.imem_ready) begin
                    ir_q <= mem.imem_data;
                    pc   <= pc + PC_W'(1);
                end
                S_DECODE: begin
                    a_q <= rf[rs];
                    b_q <= rf[rt];
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (op == OP_BEQ && zero) pc <= pc + pc_off;
                end
                S_MEM: if (mem.dmem_ready && op == OP_LW) mdr_q <= mem.dmem_rdata;
                // rf[0] is never written, so it reads as zero without a read-side mux.
                S_WB: if (wb_dest != 2'd0) rf[wb_dest] <= (op == OP_LW) ? mdr_q : alu_q;
                default: ;
            endcase
        end
    end
endmodule
